// File: rtl/secure_router_p.sv
// Multi-port Hamming(7,4)/SECDED serial router: accepts nibbles over valid/ready,
// encodes them and shifts each codeword MSB-first out of the addressed port.
module secure_router_p #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned EXT_PARITY = 0,
  localparam int unsigned PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PORT_W-1:0]    in_port,
  input  logic [3:0]           in_data,
  output logic [NUM_PORTS-1:0] data_out,
  output logic [NUM_PORTS-1:0] strobe_out,
  output logic [NUM_PORTS-1:0] frame_done,
  output logic                 err_drop
);

  localparam int unsigned L     = (EXT_PARITY != 0) ? 8 : 7;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(L - 2);

  logic [L-1:0]         shreg [NUM_PORTS];
  logic [CNT_W-1:0]     cnt   [NUM_PORTS];
  logic [L-1:0]         cw;
  logic                 port_ok;
  logic [NUM_PORTS-1:0] load;

  function automatic logic [6:0] hamming(input logic [3:0] d);
    return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
            d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
  endfunction

  // Frame to transmit, MSB first; overall parity trails the Hamming bits
  always_comb begin
    cw = '0;
    if (EXT_PARITY != 0) cw = L'({hamming(in_data), ^hamming(in_data)});
    else                 cw = L'(hamming(in_data));
  end

  // A port can take a new word when idle or showing its final bit
  always_comb begin
    in_ready = 1'b1;
    port_ok  = 1'b0;
    load     = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (in_port == PORT_W'(p)) begin
        port_ok  = 1'b1;
        in_ready = !strobe_out[p] || (cnt[p] == LAST);
        load[p]  = in_valid && (!strobe_out[p] || (cnt[p] == LAST));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      strobe_out <= '0;
      frame_done <= '0;
      err_drop   <= 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        shreg[p] <= '0;
        cnt[p]   <= '0;
      end
    end else begin
      err_drop <= in_valid && !port_ok;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (load[p]) begin
          shreg[p]      <= cw;
          cnt[p]        <= '0;
          data_out[p]   <= cw[L-1];
          strobe_out[p] <= 1'b1;
          frame_done[p] <= 1'b0;
        end else if (strobe_out[p] && (cnt[p] != LAST)) begin
          shreg[p]      <= shreg[p] << 1;
          cnt[p]        <= cnt[p] + CNT_W'(1);
          data_out[p]   <= shreg[p][L-2];
          frame_done[p] <= (cnt[p] == PENULT);
        end else begin
          cnt[p]        <= '0;
          data_out[p]   <= 1'b0;
          strobe_out[p] <= 1'b0;
          frame_done[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/secure_router_p.md
Name: secure_router_p

Overview:
Parametrised successor to the fixed 4-port Hamming(7,4) serial router. It accepts 4-bit data words addressed to one of NUM_PORTS output ports over a valid/ready handshake, Hamming-encodes each word, and serialises the codeword MSB-first on the addressed port, with a strobe framing each bit. Every port has its own shift register and counter, so different ports serialise concurrently. An optional extended-parity mode (SECDED, 8-bit frame) is provided. Same-port frames can be issued back-to-back with no gap.

Parameters:
NUM_PORTS, 4, number of serial output ports (2..16).
EXT_PARITY, 0, 1 = append overall parity bit (frame length L=8); 0 = plain Hamming(7,4) (L=7).
PORT_W (localparam), max(1,clog2(NUM_PORTS)), width of in_port.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  router can accept the word on in_port (combinational)
in_port  input  PORT_W  destination port index
in_data  input  4  data nibble d[3:0]
data_out  output  NUM_PORTS  serial data, one bit per port
strobe_out  output  NUM_PORTS  high while the corresponding data_out bit is valid
frame_done  output  NUM_PORTS  1-cycle pulse coincident with last bit of a frame
err_drop  output  1  1-cycle pulse: word addressed to nonexistent port was discarded

Behaviour:
- Reset (async, any time, including mid-frame): data_out=0, strobe_out=0, frame_done=0, err_drop=0, all per-port counters/busy=0. In-flight frames are aborted and never resumed.
- Codeword c[6:0]: c6=d3^d2^d0, c5=d3^d1^d0, c4=d3, c3=d2^d1^d0, c2=d2, c1=d1, c0=d0. With EXT_PARITY=1, c7 = XOR of c[6:0], sent after c0.
- Transmit order: c6,c5,c4,c3,c2,c1,c0[,c7].
- Accept: a transfer occurs on the rising edge where in_valid & in_ready are both 1.
- in_ready: 1 when port in_port is idle, or is in its last-bit cycle (bit index L-1). in_ready is also 1 when in_port >= NUM_PORTS. in_ready depends only on in_port and the per-port state, not on in_valid.
- Latency: at the accept edge, port p loads the codeword and drives data_out[p]=c6, strobe_out[p]=1. Bit k is therefore valid in the (k+1)-th cycle after the accept edge.
- strobe_out[p] stays high for exactly L consecutive cycles per frame. data_out[p]=0 and strobe_out[p]=0 when idle.
- frame_done[p]=1 during the cycle bit L-1 is driven.
- Back-to-back on the same port: if accept happens during the last-bit cycle, the next frame's c6 follows immediately. strobe_out stays continuously high and frame_done still pulses for the completed frame.
- Ports are independent. A word for port q is accepted while port p≠q is busy, and simultaneous activity on all ports is legal.
- Invalid port (in_port >= NUM_PORTS) with in_valid=1: the word is accepted and discarded. err_drop=1 for one cycle after the edge, and no port state changes.
- in_data and in_port are sampled only at the accept edge; changes while a port is busy have no effect on the frame in flight.
- Per-port state: idle/busy flag, shift register of L bits, bit counter 0..L-1 (wraps to idle or reload).

Test Plan:
1. NUM_PORTS=4, EXT_PARITY=0: send port 2, data 4'b1011 -> data_out[2] = 0,1,1,0,0,1,1 over 7 cycles with strobe_out[2]=1; frame_done[2] pulses on the 7th cycle; other ports stay 0.
2. EXT_PARITY=1: send port 0, data 4'b1111 -> bits 1,1,1,1,1,1,1,1 over 8 cycles. Then send data 4'b1011 -> bits 0,1,1,0,0,1,1,0.
3. Back-to-back: hold in_valid on port 1 with 4'b0000 then 4'b1111 -> in_ready low for cycles 1-6 and high in the last-bit cycle. Output is 14 contiguous strobe cycles, bits 0×7 then 1×7, with two frame_done pulses.
4. Concurrency: accept port 0 data 4'b1011, next cycle accept port 3 data 4'b1111 -> both ports serialise correctly, offset by one cycle. in_ready is 0 for port 0 and 1 for port 2 during this time.
5. NUM_PORTS=3: in_port=3, in_valid=1 -> in_ready=1, err_drop pulses once, and all strobe_out stay 0.
6. Assert rst asynchronously at bit 3 of a port-1 frame -> outputs go 0 immediately. After release, in_ready=1 for port 1 and no residual bits appear.
